// File: rtl/ifetch_queue.sv
// ifetch_queue: single-outstanding instruction fetcher with static branch
// prediction (backward branches and JAL taken) feeding a small circular
// instruction queue toward decode. A ROB flush empties the queue, redirects
// the PC and, when a fetch is still in flight, discards its late response.
module ifetch_queue #(
   parameter int          IQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        ic_req,
   output logic [31:0] ic_addr,
   input  logic        ic_valid,
   input  logic [31:0] ic_ins,
   output logic        decode_flag,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic [31:0] ins_pred_pc,
   input  logic        decode_ok,
   input  logic        rob_clear,
   input  logic [31:0] rob_new_pc
);

   localparam int PW = $clog2(IQ_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   r_addr;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [31:0]   r_ins_q  [IQ_DEPTH];
   logic [31:0]   r_pc_q   [IQ_DEPTH];
   logic [31:0]   r_pred_q [IQ_DEPTH];

   logic          w_req;
   logic          w_push;
   logic          w_pop;
   logic          w_active;
   logic [31:0]   w_pred;
   logic [31:0]   w_jimm;
   logic [31:0]   w_bimm;

   // Cycle is live only out of reset and with the global ready high.
   assign w_active = rst_in && rdy_in;

   // Static prediction: JAL always taken, conditional branch taken only when backward.
   always_comb begin
      w_jimm = {{12{ic_ins[31]}}, ic_ins[19:12], ic_ins[20], ic_ins[30:21], 1'b0};
      w_bimm = {{20{ic_ins[31]}}, ic_ins[7], ic_ins[30:25], ic_ins[11:8], 1'b0};
      w_pred = r_pc + 32'd4;
      if (ic_ins[6:0] == 7'b1101111)
         w_pred = r_pc + w_jimm;
      else if (ic_ins[6:0] == 7'b1100011 && ic_ins[31])
         w_pred = r_pc + w_bimm;
   end

   // Decode sees the head only when nothing is flushing or stalling the block.
   assign decode_flag = (r_count != '0) && w_active && !rob_clear;
   assign w_pop       = decode_flag && decode_ok;
   assign ins         = r_ins_q[r_head];
   assign ins_pc      = r_pc_q[r_head];
   assign ins_pred_pc = r_pred_q[r_head];

   // The address is live from the PC in the request cycle, then held from r_addr
   // so a flushed-but-outstanding fetch keeps showing its original address.
   assign ic_addr = (r_state == S_IDLE) ? r_pc : r_addr;
   assign ic_req  = w_req;

   // Next-state and request/push decisions; flush wins over everything.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_push      = 1'b0;
      if (w_active) begin
         case (r_state)
            S_IDLE: begin
               if (!rob_clear && r_count < DEPTH_C) begin
                  w_req       = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (rob_clear)
                  w_state_nxt = ic_valid ? S_IDLE : S_DISCARD;
               else if (ic_valid) begin
                  w_push      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_DISCARD: begin
               // The stale response always retires the discard, even alongside
               // another flush, otherwise nothing would ever leave this state.
               if (ic_valid)
                  w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in) begin
      if (!rst_in)
         r_state <= S_IDLE;
      else if (rdy_in)
         r_state <= w_state_nxt;
   end

   // PC, held request address, queue pointers and occupancy.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy_in) begin
         if (w_req)
            r_addr <= r_pc;
         if (rob_clear) begin
            r_pc    <= rob_new_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_pc   <= w_pred;
               r_tail <= r_tail + PW'(1);
            end
            if (w_pop)
               r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Queue storage; contents need no reset since occupancy gates their use.
   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_ins_q[r_tail]  <= ic_ins;
         r_pc_q[r_tail]   <= r_pc;
         r_pred_q[r_tail] <= w_pred;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed stimulus queues expected fetch
// addresses and decoded entries; a negedge monitor compares them as the DUT
// presents requests and pops.
module tb_ifetch_queue;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, ic_valid, decode_ok, rob_clear;
   logic [31:0] ic_ins, rob_new_pc;
   logic        ic_req, decode_flag;
   logic [31:0] ic_addr, ins, ins_pc, ins_pred_pc;

   typedef struct packed {
      logic [31:0] w;
      logic [31:0] pc;
      logic [31:0] pred;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] addr_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   ifetch_queue #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_ins(ic_ins),
      .decode_flag(decode_flag), .ins(ins), .ins_pc(ins_pc), .ins_pred_pc(ins_pred_pc),
      .decode_ok(decode_ok), .rob_clear(rob_clear), .rob_new_pc(rob_new_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic exp_fetch(input logic [31:0] a, input logic [31:0] w, input logic [31:0] p);
      ent_t e;
      e = {w, a, p};
      addr_q.push_back(a);
      exp_q.push_back(e);
   endtask

   task automatic wait_req(output int waited);
      waited = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         if (ic_req) begin
            waited = i;
            break;
         end
      end
      if (waited < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL req_timeout: no ic_req within 20 cycles");
      end
   endtask

   task automatic respond_now(input logic [31:0] w);
      tick;
      ic_valid = 1'b1;
      ic_ins   = w;
      tick;
      ic_valid = 1'b0;
   endtask

   task automatic respond(input logic [31:0] w);
      int wt;
      wait_req(wt);
      respond_now(w);
   endtask

   // Monitor: every request address and every consumed head is scored.
   always @(negedge clk_in) begin
      ent_t e;
      if (rst_in && ic_req) begin
         n_cmp++;
         if (addr_q.size() == 0) begin
            n_bad++;
            $display("FAIL req_unexpected: got addr %h expected no request", ic_addr);
         end else begin
            logic [31:0] a;
            a = addr_q.pop_front();
            if (ic_addr !== a) begin
               n_bad++;
               $display("FAIL req_addr: got %h expected %h", ic_addr, a);
            end
         end
      end
      if (decode_flag && decode_ok) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected: got pc %h expected no entry", ins_pc);
         end else begin
            e = exp_q.pop_front();
            if ({ins, ins_pc, ins_pred_pc} !== e) begin
               n_bad++;
               $display("FAIL pop: got ins %h pc %h pred %h expected ins %h pc %h pred %h",
                        ins, ins_pc, ins_pred_pc, e.w, e.pc, e.pred);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int wt;
      ent_t e;
      rst_in = 1'b0; rdy_in = 1'b1; ic_valid = 1'b0; ic_ins = '0;
      decode_ok = 1'b0; rob_clear = 1'b0; rob_new_pc = '0;
      repeat (2) tick;
      @(negedge clk_in);
      check("rst_ic_req", 32'(ic_req), 32'd0);
      check("rst_decode_flag", 32'(decode_flag), 32'd0);
      tick;
      rst_in = 1'b1;

      // Fill the queue with NOPs, decode stalled.
      for (int i = 0; i < 4; i++)
         exp_fetch(32'(i * 4), 32'h00000013, 32'(i * 4 + 4));
      wait_req(wt);
      check("first_req_latency", 32'(wt), 32'd0);
      respond_now(32'h00000013);
      repeat (3) respond(32'h00000013);
      // Full: no request; a stray response in IDLE must be ignored.
      ic_valid = 1'b1;
      ic_ins   = 32'hDEADBEEF;
      repeat (3) begin
         @(negedge clk_in);
         check("full_no_req", 32'(ic_req), 32'd0);
      end
      check("full_decode_flag", 32'(decode_flag), 32'd1);
      check("full_head_pc", ins_pc, 32'h0);
      tick;
      ic_valid = 1'b0;

      // Pop one, then push and pop together with the tail wrapped.
      addr_q.push_back(32'h10);
      e = {32'h00100093, 32'h10, 32'h14};
      exp_q.push_back(e);
      exp_fetch(32'h14, 32'h00000013, 32'h18);
      decode_ok = 1'b1;
      tick;
      decode_ok = 1'b0;
      wait_req(wt);
      tick;
      ic_valid = 1'b1; ic_ins = 32'h00100093; decode_ok = 1'b1;
      tick;
      ic_valid = 1'b0; decode_ok = 1'b0;
      respond(32'h00000013);
      repeat (2) begin
         @(negedge clk_in);
         check("full2_no_req", 32'(ic_req), 32'd0);
      end
      check("head_advanced", ins_pc, 32'h8);
      check("full2_decode_flag", 32'(decode_flag), 32'd1);

      // Drain three; a fetch to 0x18 goes out and is left outstanding.
      addr_q.push_back(32'h18);
      tick;
      decode_ok = 1'b1;
      repeat (3) tick;
      decode_ok = 1'b0;

      // Flush while waiting; the late response must be discarded.
      rob_clear = 1'b1; rob_new_pc = 32'h200;
      @(negedge clk_in);
      check("flush_decode_flag", 32'(decode_flag), 32'd0);
      check("flush_no_req", 32'(ic_req), 32'd0);
      exp_q.delete();
      tick;
      rob_clear = 1'b0;
      @(negedge clk_in);
      check("discard_addr_held", ic_addr, 32'h18);
      check("discard_no_req", 32'(ic_req), 32'd0);
      tick;
      ic_valid = 1'b1; ic_ins = 32'h00000013;
      addr_q.push_back(32'h200);
      tick;
      ic_valid = 1'b0;
      @(negedge clk_in);
      check("stale_dropped", 32'(decode_flag), 32'd0);
      check("redirect_req", 32'(ic_req), 32'd1);
      respond_now(32'h00000013);

      // Flush in IDLE coinciding with a would-be request.
      rob_clear = 1'b1; rob_new_pc = 32'h40;
      @(negedge clk_in);
      check("idle_flush_no_req", 32'(ic_req), 32'd0);
      check("idle_flush_decode", 32'(decode_flag), 32'd0);
      exp_q.delete();
      tick;
      rob_clear = 1'b0;
      decode_ok = 1'b1;

      // JAL backward at 0x40, then redirect to 0x100 for branch tests.
      exp_fetch(32'h40, 32'hFF1FF06F, 32'h30);
      exp_fetch(32'h30, 32'h00000013, 32'h34);
      respond(32'hFF1FF06F);
      respond(32'h00000013);
      rob_clear = 1'b1; rob_new_pc = 32'h100;
      @(negedge clk_in);
      check("head_pred_0x30", ins_pred_pc, 32'h34);
      check("flush2_no_req", 32'(ic_req), 32'd0);
      exp_q.delete();
      tick;
      rob_clear = 1'b0;

      // Backward BEQ, NOP, forward BEQ.
      exp_fetch(32'h100, 32'hFE000EE3, 32'hFC);
      exp_fetch(32'hFC,  32'h00000013, 32'h100);
      exp_fetch(32'h100, 32'h00000463, 32'h104);
      addr_q.push_back(32'h104);
      respond(32'hFE000EE3);
      respond(32'h00000013);
      respond(32'h00000463);
      decode_ok = 1'b0;

      // Stall three cycles while waiting on 0x104.
      tick;
      rdy_in = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         check("stall_no_req", 32'(ic_req), 32'd0);
         check("stall_decode_flag", 32'(decode_flag), 32'd0);
         check("stall_addr", ic_addr, 32'h104);
         check("stall_head_pc", ins_pc, 32'h100);
         tick;
      end
      rdy_in = 1'b1;
      ic_valid = 1'b1; ic_ins = 32'h00000013;
      e = {32'h00000013, 32'h104, 32'h108};
      exp_q.push_back(e);
      addr_q.push_back(32'h108);
      @(negedge clk_in);
      check("resume_decode_flag", 32'(decode_flag), 32'd1);
      tick;
      ic_valid = 1'b0; decode_ok = 1'b1;
      repeat (2) tick;
      decode_ok = 1'b0;
      repeat (3) tick;

      check("exp_left", 32'(exp_q.size()), 32'd0);
      check("addr_left", 32'(addr_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 4, instruction-queue entries, power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-low.
REQ-005 rdy_in  input  1  global ready; low freezes all state.
REQ-006 ic_req  output  1  single-cycle fetch request pulse to the instruction cache.
REQ-007 ic_addr  output  32  fetch address; held stable from the ic_req cycle until the matching ic_valid.
REQ-008 ic_valid  input  1  one-cycle response strobe from the instruction cache.
REQ-009 ic_ins  input  32  instruction word, valid with ic_valid.
REQ-010 decode_flag  output  1  queue head valid, offered to decode.
REQ-011 ins  output  32  head instruction.
REQ-012 ins_pc  output  32  head instruction PC.
REQ-013 ins_pred_pc  output  32  head predicted next PC.
REQ-014 decode_ok  input  1  decode consumed the head this cycle.
REQ-015 rob_clear  input  1  misprediction flush.
REQ-016 rob_new_pc  input  32  redirect PC, valid with rob_clear.

Function
REQ-017 The FSM SHALL have 3 states: IDLE, WAIT, DISCARD.
REQ-018 In IDLE with count+1 <= IQ_DEPTH and no rob_clear, it SHALL pulse ic_req, drive ic_addr=pc, and enter WAIT.
REQ-019 In IDLE with the queue full, it SHALL issue no request and stay in IDLE.
REQ-020 In WAIT on ic_valid, it SHALL push {ic_ins, pc, pred} at the tail, set pc<=pred, and return to IDLE; the next request SHALL go out no earlier than the following cycle.
REQ-021 pred SHALL be computed combinationally from ic_ins and pc, with 32-bit wrap-around arithmetic, as follows:
- opcode 1101111 (JAL): pc + sign-extended J-immediate.
- opcode 1100011 (branch) with ic_ins[31]=1 (backward): pc + sign-extended B-immediate.
- all other instructions, including JALR and forward branches: pc+4.
REQ-022 At most one fetch SHALL be outstanding.
REQ-023 decode_flag SHALL equal (count!=0) && rdy_in && !rob_clear; ins, ins_pc and ins_pred_pc SHALL be driven combinationally from the head entry.
REQ-024 decode_ok with decode_flag high SHALL pop the head; decode_ok while decode_flag is low SHALL be ignored.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged; head and tail pointers wrap modulo IQ_DEPTH.
REQ-026 rob_clear SHALL take priority over every other event in that cycle:
- the queue SHALL be emptied (count=0, head=tail).
- pc SHALL be set to rob_new_pc.
- no push or pop SHALL occur.
- ic_req SHALL stay 0.
REQ-027 rob_clear in IDLE SHALL leave the FSM in IDLE.
REQ-028 rob_clear in WAIT without ic_valid SHALL move the FSM to DISCARD.
REQ-029 rob_clear in WAIT with ic_valid in the same cycle SHALL drop the response and move the FSM to IDLE.
REQ-030 rob_clear in DISCARD SHALL update pc and keep the FSM in DISCARD.
REQ-031 In DISCARD, ic_valid SHALL be dropped and the FSM SHALL move to IDLE; ic_addr SHALL keep the stale request address until then.
REQ-032 With rdy_in low, pc, the FSM, the queue and the pointers SHALL hold; ic_req SHALL be 0 and decode_flag SHALL be 0.
REQ-033 ic_valid while in IDLE SHALL be ignored.

Reset
REQ-034 When rst_in is low at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, head=tail=0, count=0.
REQ-035 During reset, ic_req SHALL be 0 and decode_flag SHALL be 0; queue contents are don't-care.
REQ-036 Reset SHALL override rdy_in and rob_clear, and SHALL abandon any outstanding fetch without entering DISCARD.
REQ-037 The first ic_req SHALL pulse in the first cycle after rst_in returns high with rdy_in high, with ic_addr=RESET_PC.

Verification
REQ-038 Reset release, then responses of 32'h00000013 one cycle after each request, with decode_ok tied low:
- ic_addr sequence SHALL be 0, 4, 8, 12.
- after 4 pushes, ic_req SHALL stay low.
- decode_flag=1 with ins_pc=0.
REQ-039 JAL backward: ic_ins=32'hFF1FF06F (JAL x0,-16) fetched at pc=32'h40 SHALL push ins_pred_pc=32'h30, and the next ic_addr SHALL be 32'h30.
REQ-040 Backward BEQ: 32'hFE000EE3 (offset -4) at pc=32'h100 SHALL predict 32'hFC. Forward BEQ: 32'h00000463 (offset +8) at the same pc SHALL predict 32'h104.
REQ-041 Queue full (count=4) with decode_ok and ic_valid asserted in the same cycle: count SHALL stay 4, the head SHALL advance, and a new entry SHALL land at the wrapped tail.
REQ-042 rob_clear with rob_new_pc=32'h200 while in WAIT, with the stale ic_valid arriving 2 cycles later:
- that response SHALL NOT be pushed.
- decode_flag SHALL be 0.
- the next ic_req SHALL carry ic_addr=32'h200.
REQ-043 rdy_in low for 3 cycles while in WAIT with ic_valid absent: all outputs SHALL hold; after rdy_in rises, ic_valid SHALL complete the push normally.
